load_store_unit: RTL and testbench

Load/store unit between the execute stage and the data memory. Accepts one load or store request per handshake, checks alignment and range, and issues word-wide accesses to memory. Sub-word stores run as read-modify-write, so memory only ever sees whole-word writes. Loads return sign- or zero-extended data on a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_align.sv | 47 ++++
 rtl/load_store_unit.sv | 138 +++++++++++++
 tb/tb_load_store_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// width codes and the word-store opcode driven to the data memory.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    RESP,
    ERR
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] STORE_WORD = 3'b010;

  // 768 data words of 4 bytes each
  localparam int unsigned ADDR_LIMIT_DEFAULT = 3072;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: merges sub-word store data into the read word
// and extracts/extends sub-word load data from the read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] store_word,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = rdata[{byte_off, 3'b000} +: 8];
  assign lane_half = rdata[{byte_off[1], 4'b0000} +: 16];

  always_comb begin
    store_word = wdata;
    case (f3)
      F3_B: begin
        store_word = rdata;
        store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
      end
      F3_H: begin
        store_word = rdata;
        store_word[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

  always_comb begin
    load_data = 32'h0;
    case (f3)
      F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_BU:   load_data = {24'h0, lane_byte};
      F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
      F3_HU:   load_data = {16'h0, lane_half};
      F3_W:    load_data = rdata;
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request per handshake, validates it, and
// performs word-wide memory accesses (read-modify-write for SB/SH).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_address,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic        reg_read_enable,
  output logic [2:0]  store_operation,
  output logic [31:0] reg_data,
  input  logic [31:0] mem_read_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_error
);

  lsu_state_t  state_q, state_next;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  f3_q;
  logic        st_q;

  logic        f3_ok, align_ok, range_ok, req_legal, accept;
  logic [31:0] merged_word, load_word;

  always_comb begin
    f3_ok    = 1'b0;
    align_ok = 1'b0;
    case (req_funct3)
      F3_B:  begin f3_ok = 1'b1;          align_ok = 1'b1;                 end
      F3_H:  begin f3_ok = 1'b1;          align_ok = ~req_addr[0];         end
      F3_W:  begin f3_ok = 1'b1;          align_ok = (req_addr[1:0] == 2'b00); end
      F3_BU: begin f3_ok = ~req_is_store; align_ok = 1'b1;                 end
      F3_HU: begin f3_ok = ~req_is_store; align_ok = ~req_addr[0];         end
      default: begin f3_ok = 1'b0;        align_ok = 1'b0;                 end
    endcase
  end

  assign range_ok  = (req_addr < 32'(ADDR_LIMIT));
  assign req_legal = f3_ok & align_ok & range_ok;
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      f3_q    <= 3'b000;
      wdata_q <= 32'h0;
      st_q    <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_next;
      if (accept) begin
        addr_q  <= req_addr;
        f3_q    <= req_funct3;
        wdata_q <= req_wdata;
        st_q    <= req_is_store;
      end
      if (state_q == READ) begin
        rdata_q <= mem_read_data;
      end
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!req_legal)
            state_next = ERR;
          else if (req_is_store && req_funct3 == F3_W)
            state_next = WRITE;
          else
            state_next = READ;
        end
      end
      READ:    state_next = st_q ? WRITE : RESP;
      WRITE:   state_next = IDLE;
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  lsu_align u_align (
    .f3         (f3_q),
    .byte_off   (addr_q[1:0]),
    .rdata      (rdata_q),
    .wdata      (wdata_q),
    .store_word (merged_word),
    .load_data  (load_word)
  );

  assign mem_address     = {addr_q[31:2], 2'b00};
  assign store_operation = STORE_WORD;

  always_comb begin
    req_ready        = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    reg_read_enable  = 1'b0;
    reg_data         = 32'h0;
    resp_valid       = 1'b0;
    resp_data        = 32'h0;
    resp_error       = 1'b0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      READ: mem_read_enable = 1'b1;
      WRITE: begin
        mem_write_enable = 1'b1;
        reg_read_enable  = 1'b1;
        reg_data         = merged_word;
        resp_valid       = 1'b1;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_data  = load_word;
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_error = 1'b1;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of requests against a
// small word memory model, plus reset-during-operation sequence.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_address;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic        reg_read_enable;
  logic [2:0]  store_operation;
  logic [31:0] reg_data;
  logic [31:0] mem_read_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_is_store     (req_is_store),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .mem_address      (mem_address),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .reg_read_enable  (reg_read_enable),
    .store_operation  (store_operation),
    .reg_data         (reg_data),
    .mem_read_data    (mem_read_data),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .resp_error       (resp_error)
  );

  // data memory model: combinational read, writes to words 0 discarded
  logic [31:0] mem [0:767] = '{5: 32'hFFFFFFE0, default: 32'h0};

  assign mem_read_data = (mem_address < 32'd3072) ? mem[mem_address[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write_enable && mem_address >= 32'd4 && mem_address < 32'd3072)
      mem[mem_address[11:2]] <= reg_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_lat;
    logic [31:0] exp_wdata;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic er, input logic [31:0] d,
                              input int lat, input logic [31:0] ewd);
    vec_t v;
    v.is_store = st; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.exp_err = er; v.exp_data = d; v.exp_lat = lat; v.exp_wdata = ewd;
    return v;
  endfunction

  task automatic do_txn(input int idx, input vec_t v);
    int          got_lat = 0;
    int          wr_cnt = 0;
    int          wr_cyc = 0;
    int          rd_cnt = 0;
    int          rre_bad = 0;
    logic [31:0] got_data = 32'h0;
    logic        got_err = 1'b0;
    logic [31:0] wr_addr = 32'h0;
    logic [31:0] wr_data = 32'h0;
    @(negedge clk);
    check($sformatf("ready_before_%0d", idx), {31'h0, req_ready}, 32'h1);
    req_valid    = 1'b1;
    req_is_store = v.is_store;
    req_funct3   = v.f3;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (reg_read_enable !== mem_write_enable) rre_bad++;
      if (mem_read_enable) rd_cnt++;
      if (mem_write_enable) begin
        wr_cnt++;
        wr_cyc  = c;
        wr_addr = mem_address;
        wr_data = reg_data;
      end
      if (resp_valid) begin
        got_lat  = c;
        got_data = resp_data;
        got_err  = resp_error;
        break;
      end
    end
    $display("txn %0d: st=%0b f3=%03b addr=%h lat=%0d data=%h err=%0b wr=%0d", idx,
             v.is_store, v.f3, v.addr, got_lat, got_data, got_err, wr_cnt);
    check($sformatf("latency_%0d", idx), got_lat, v.exp_lat);
    check($sformatf("resp_data_%0d", idx), got_data, v.exp_data);
    check($sformatf("resp_error_%0d", idx), {31'h0, got_err}, {31'h0, v.exp_err});
    check($sformatf("reg_read_en_%0d", idx), rre_bad, 0);
    if (v.exp_err) begin
      check($sformatf("err_no_strobe_%0d", idx), rd_cnt + wr_cnt, 0);
    end else if (v.is_store) begin
      check($sformatf("wr_count_%0d", idx), wr_cnt, 1);
      check($sformatf("wr_cycle_%0d", idx), wr_cyc, v.exp_lat);
      check($sformatf("wr_addr_%0d", idx), wr_addr, {v.addr[31:2], 2'b00});
      check($sformatf("wr_data_%0d", idx), wr_data, v.exp_wdata);
    end else begin
      check($sformatf("load_rd_%0d", idx), rd_cnt, 1);
      check($sformatf("load_no_wr_%0d", idx), wr_cnt, 0);
    end
    @(negedge clk);
    check($sformatf("resp_single_%0d", idx), {31'h0, resp_valid}, 32'h0);
    check($sformatf("ready_after_%0d", idx), {31'h0, req_ready}, 32'h1);
  endtask

  vec_t vecs [$];

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = 3'b000;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;

    //    st    f3      addr          wdata         err   data          lat  write word
    vecs.push_back(mk(1'b0, 3'b000, 32'h14,  32'h0,        1'b0, 32'hFFFFFFE0, 2, 32'h0));
    vecs.push_back(mk(1'b0, 3'b100, 32'h14,  32'h0,        1'b0, 32'h000000E0, 2, 32'h0));
    vecs.push_back(mk(1'b0, 3'b001, 32'h16,  32'h0,        1'b0, 32'hFFFFFFFF, 2, 32'h0));
    vecs.push_back(mk(1'b0, 3'b101, 32'h16,  32'h0,        1'b0, 32'h0000FFFF, 2, 32'h0));
    vecs.push_back(mk(1'b0, 3'b010, 32'h14,  32'h0,        1'b0, 32'hFFFFFFE0, 2, 32'h0));
    vecs.push_back(mk(1'b1, 3'b000, 32'h15,  32'h000000AB, 1'b0, 32'h0,        2, 32'hFFFFABE0));
    vecs.push_back(mk(1'b0, 3'b010, 32'h14,  32'h0,        1'b0, 32'hFFFFABE0, 2, 32'h0));
    vecs.push_back(mk(1'b1, 3'b010, 32'h20,  32'h12345678, 1'b0, 32'h0,        1, 32'h12345678));
    vecs.push_back(mk(1'b0, 3'b010, 32'h20,  32'h0,        1'b0, 32'h12345678, 2, 32'h0));
    vecs.push_back(mk(1'b0, 3'b010, 32'h16,  32'h0,        1'b1, 32'h0,        1, 32'h0));
    vecs.push_back(mk(1'b0, 3'b001, 32'h13,  32'h0,        1'b1, 32'h0,        1, 32'h0));
    vecs.push_back(mk(1'b0, 3'b011, 32'h14,  32'h0,        1'b1, 32'h0,        1, 32'h0));
    vecs.push_back(mk(1'b0, 3'b010, 32'hC00, 32'h0,        1'b1, 32'h0,        1, 32'h0));
    vecs.push_back(mk(1'b1, 3'b001, 32'h22,  32'h0000BEEF, 1'b0, 32'h0,        2, 32'hBEEF5678));
    vecs.push_back(mk(1'b0, 3'b101, 32'h22,  32'h0,        1'b0, 32'h0000BEEF, 2, 32'h0));
    vecs.push_back(mk(1'b0, 3'b100, 32'h21,  32'h0,        1'b0, 32'h00000056, 2, 32'h0));
    vecs.push_back(mk(1'b1, 3'b000, 32'h17,  32'h00000080, 1'b0, 32'h0,        2, 32'h80FFABE0));
    vecs.push_back(mk(1'b0, 3'b000, 32'h17,  32'h0,        1'b0, 32'hFFFFFF80, 2, 32'h0));
    vecs.push_back(mk(1'b1, 3'b100, 32'h14,  32'h0,        1'b1, 32'h0,        1, 32'h0));
    vecs.push_back(mk(1'b1, 3'b011, 32'h14,  32'h0,        1'b1, 32'h0,        1, 32'h0));
    vecs.push_back(mk(1'b0, 3'b101, 32'h15,  32'h0,        1'b1, 32'h0,        1, 32'h0));
    vecs.push_back(mk(1'b1, 3'b010, 32'hBFC, 32'hCAFEF00D, 1'b0, 32'h0,        1, 32'hCAFEF00D));
    vecs.push_back(mk(1'b0, 3'b010, 32'hBFC, 32'h0,        1'b0, 32'hCAFEF00D, 2, 32'h0));
    vecs.push_back(mk(1'b1, 3'b010, 32'hC00, 32'h11111111, 1'b1, 32'h0,        1, 32'h0));
    vecs.push_back(mk(1'b1, 3'b010, 32'h0,   32'hDEADBEEF, 1'b0, 32'h0,        1, 32'hDEADBEEF));
    vecs.push_back(mk(1'b0, 3'b010, 32'h0,   32'h0,        1'b0, 32'h0,        2, 32'h0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_strobes", {29'h0, mem_read_enable, mem_write_enable, reg_read_enable}, 32'h0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_store_op", {29'h0, store_operation}, 32'h2);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_outputs", {resp_data[15:0], reg_data[15:0]} | {31'h0, resp_error}, 32'h0);

    foreach (vecs[i]) do_txn(i, vecs[i]);

    // reset while the SH read is outstanding must abort the request
    @(negedge clk);
    req_valid    = 1'b1;
    req_is_store = 1'b1;
    req_funct3   = 3'b001;
    req_addr     = 32'h22;
    req_wdata    = 32'h00001111;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_read", {31'h0, mem_read_enable}, 32'h1);
    reset = 1'b1;
    #1;
    check("abort_rst_ready", {31'h0, req_ready}, 32'h1);
    begin
      int bad = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (c == 2) reset = 1'b0;
        if (mem_write_enable || resp_valid) bad++;
      end
      $display("txn abort: SH 0x22 reset in READ, strobes/responses seen=%0d", bad);
      check("abort_no_write_resp", bad, 0);
    end
    check("abort_ready_after", {31'h0, req_ready}, 32'h1);
    check("abort_mem_unchanged", mem[8], 32'hBEEF5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, expected finish");
    $fatal(1);
  end

endmodule
